// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

   typedef enum logic [2:0] {PRST, WAIT, STABLE, RUN, FAULT} chanState_t;

   // Width of the shared per-channel timer, which must hold the largest terminal count.
   function automatic int timerWidth(input int rstPulse, input int stableCyc, input int timeoutCyc);
      int m;
      int w;
      m = rstPulse;
      if (stableCyc > m) m = stableCyc;
      if (timeoutCyc > m) m = timeoutCyc;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int retryWidth(input int maxRetries);
      int w;
      w = $clog2(maxRetries + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pll_sup_chan.sv
// One supervised PLL channel: lock synchronizer, sequencing FSM, timer, retry and loss counters.
module pll_sup_chan
   import pll_sup_pkg::*;
#(
   parameter int RST_PULSE_CYC = 50,
   parameter int STABLE_CYC    = 5000,
   parameter int TIMEOUT_CYC   = 50000,
   parameter int MAX_RETRIES   = 3,
   parameter int EVT_W         = 8
) (
   input  logic             i_refclk,
   input  logic             i_rst,
   input  logic             i_locked,
   input  logic             i_fault_clr,
   output logic             o_pll_rst,
   output logic             o_domain_rst,
   output logic             o_fault,
   output logic             o_run,
   output logic [EVT_W-1:0] o_loss_cnt
);

   localparam int TMR_W = timerWidth(RST_PULSE_CYC, STABLE_CYC, TIMEOUT_CYC);
   localparam int RETRY_W = retryWidth(MAX_RETRIES);
   localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_PULSE_CYC - 1);
   localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYC - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);
   localparam logic [EVT_W-1:0] CNT_SAT = '1;

   logic               r_sync1;
   logic               r_sync2;
   logic               w_lk;
   chanState_t         r_state;
   logic [TMR_W-1:0]   r_timer;
   logic [RETRY_W-1:0] r_retry;
   logic [EVT_W-1:0]   r_lossCnt;
   logic               r_pllRst;
   logic               r_domainRst;
   logic               r_fault;

   // locked comes from the PLL's own clock domain, so bring it in through two flops.
   always_ff @(posedge i_refclk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_locked;
         r_sync2 <= r_sync1;
      end
   end

   assign w_lk = r_sync2;

   // Outputs are decoded from the current state, so they follow a transition by one cycle.
   always_ff @(posedge i_refclk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= PRST;
         r_timer     <= '0;
         r_retry     <= '0;
         r_lossCnt   <= '0;
         r_pllRst    <= 1'b1;
         r_domainRst <= 1'b1;
         r_fault     <= 1'b0;
      end else begin
         r_pllRst    <= (r_state == PRST) || (r_state == FAULT);
         r_domainRst <= (r_state != RUN);
         r_fault     <= (r_state == FAULT);
         case (r_state)
            PRST: begin
               if (r_timer == RST_LAST) begin
                  r_state <= WAIT;
                  r_timer <= '0;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            WAIT: begin
               if (w_lk) begin
                  r_state <= STABLE;
                  r_timer <= '0;
               end else if (r_timer == TIMEOUT_LAST) begin
                  r_timer <= '0;
                  r_retry <= r_retry + 1'b1;
                  r_state <= (r_retry == RETRY_LAST) ? FAULT : PRST;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            STABLE: begin
               if (!w_lk) begin
                  r_state <= WAIT;
                  r_timer <= '0;
               end else if (r_timer == STABLE_LAST) begin
                  r_state <= RUN;
                  r_timer <= '0;
                  r_retry <= '0;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            RUN: begin
               if (!w_lk) begin
                  r_state <= PRST;
                  r_timer <= '0;
                  if (r_lossCnt != CNT_SAT) r_lossCnt <= r_lossCnt + 1'b1;
               end
            end
            FAULT: begin
               if (i_fault_clr) begin
                  r_state <= PRST;
                  r_timer <= '0;
                  r_retry <= '0;
               end
            end
            default: begin
               r_state <= PRST;
               r_timer <= '0;
            end
         endcase
      end
   end

   assign o_pll_rst    = r_pllRst;
   assign o_domain_rst = r_domainRst;
   assign o_fault      = r_fault;
   assign o_run        = (r_state == RUN);
   assign o_loss_cnt   = r_lossCnt;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervises NUM_PLLS PLLs from the reference clock and gates the per-domain resets.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int NUM_PLLS      = 2,
   parameter int RST_PULSE_CYC = 50,
   parameter int STABLE_CYC    = 5000,
   parameter int TIMEOUT_CYC   = 50000,
   parameter int MAX_RETRIES   = 3,
   parameter int EVT_W         = 8
) (
   input  logic                      i_refclk,
   input  logic                      i_rst,
   input  logic [NUM_PLLS-1:0]       i_locked_in,
   input  logic [NUM_PLLS-1:0]       i_fault_clr,
   output logic [NUM_PLLS-1:0]       o_pll_rst,
   output logic [NUM_PLLS-1:0]       o_domain_rst,
   output logic                      o_all_ready,
   output logic [NUM_PLLS-1:0]       o_fault,
   output logic [NUM_PLLS*EVT_W-1:0] o_lock_loss_cnt
);

   logic [NUM_PLLS-1:0] w_run;
   logic                r_allReady;

   for (genvar g = 0; g < NUM_PLLS; g++) begin : gChan
      pll_sup_chan #(
         .RST_PULSE_CYC(RST_PULSE_CYC),
         .STABLE_CYC   (STABLE_CYC),
         .TIMEOUT_CYC  (TIMEOUT_CYC),
         .MAX_RETRIES  (MAX_RETRIES),
         .EVT_W        (EVT_W)
      ) uChan (
         .i_refclk    (i_refclk),
         .i_rst       (i_rst),
         .i_locked    (i_locked_in[g]),
         .i_fault_clr (i_fault_clr[g]),
         .o_pll_rst   (o_pll_rst[g]),
         .o_domain_rst(o_domain_rst[g]),
         .o_fault     (o_fault[g]),
         .o_run       (w_run[g]),
         .o_loss_cnt  (o_lock_loss_cnt[g*EVT_W +: EVT_W])
      );
   end

   always_ff @(posedge i_refclk or posedge i_rst) begin
      if (i_rst) r_allReady <= 1'b0;
      else       r_allReady <= &w_run;
   end

   assign o_all_ready = r_allReady;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor; edge numbers count refclk rising edges after reset release.
module tb_pll_lock_supervisor;

   localparam int NUM_PLLS = 2;
   localparam int EVT_W    = 2;

   logic                      refclk;
   logic                      rst;
   logic [NUM_PLLS-1:0]       lockedIn;
   logic [NUM_PLLS-1:0]       faultClr;
   logic [NUM_PLLS-1:0]       pllRst;
   logic [NUM_PLLS-1:0]       domainRst;
   logic                      allReady;
   logic [NUM_PLLS-1:0]       fault;
   logic [NUM_PLLS*EVT_W-1:0] lossCnt;

   int checks = 0;
   int errors = 0;

   pll_lock_supervisor #(
      .NUM_PLLS     (NUM_PLLS),
      .RST_PULSE_CYC(4),
      .STABLE_CYC   (8),
      .TIMEOUT_CYC  (20),
      .MAX_RETRIES  (2),
      .EVT_W        (EVT_W)
   ) dut (
      .i_refclk       (refclk),
      .i_rst          (rst),
      .i_locked_in    (lockedIn),
      .i_fault_clr    (faultClr),
      .o_pll_rst      (pllRst),
      .o_domain_rst   (domainRst),
      .o_all_ready    (allReady),
      .o_fault        (fault),
      .o_lock_loss_cnt(lossCnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic applyStimulus(input logic [NUM_PLLS-1:0] lk, input logic [NUM_PLLS-1:0] clr);
      lockedIn = lk;
      faultClr = clr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(2'b10, 2'b00);
      tick(3);
      checkOutput("rst_pll_rst", 32'(pllRst), 32'h3);
      checkOutput("rst_domain_rst", 32'(domainRst), 32'h3);
      checkOutput("rst_all_ready", 32'(allReady), 32'h0);
      checkOutput("rst_fault", 32'(fault), 32'h0);
      checkOutput("rst_cnt", 32'(lossCnt), 32'h0);
      rst = 1'b0;

      // Test 1: PRST lasts edges 1-4, pll_rst drops at edge 5; ch1 locked throughout
      tick(4);
      checkOutput("t1_pll_rst_e4", 32'(pllRst), 32'h3);
      tick(1);
      checkOutput("t1_pll_rst_e5", 32'(pllRst), 32'h0);
      tick(5);
      applyStimulus(2'b11, 2'b00);
      // Lock raised after edge 10: sync 11,12, STABLE at 13, RUN at 21, domain_rst low at 22
      tick(11);
      checkOutput("t1_domain_rst_e21", 32'(domainRst), 32'h1);
      checkOutput("t1_all_ready_e21", 32'(allReady), 32'h0);
      tick(1);
      checkOutput("t1_domain_rst_e22", 32'(domainRst), 32'h0);
      checkOutput("t2_all_ready_e22", 32'(allReady), 32'h1);

      // Test 2: ch1 loses lock after edge 22, seen in RUN at edge 25
      applyStimulus(2'b01, 2'b00);
      tick(3);
      checkOutput("t2_all_ready_e25", 32'(allReady), 32'h1);
      checkOutput("t2_cnt_e25", 32'(lossCnt), 32'h4);
      tick(1);
      checkOutput("t2_all_ready_e26", 32'(allReady), 32'h0);
      checkOutput("t2_pll_rst_e26", 32'(pllRst), 32'h2);
      checkOutput("t2_domain_rst_e26", 32'(domainRst), 32'h2);
      applyStimulus(2'b11, 2'b00);

      // Test 3: ch1 enters STABLE at 30; locked low for 3 cycles sends it back to WAIT
      tick(6);
      applyStimulus(2'b01, 2'b00);
      tick(3);
      applyStimulus(2'b11, 2'b00);
      tick(2);
      checkOutput("t3_pll_rst_e37", 32'(pllRst), 32'h0);
      checkOutput("t3_domain_rst_e37", 32'(domainRst), 32'h2);
      tick(2);
      checkOutput("t3_domain_rst_e39", 32'(domainRst), 32'h2);
      tick(7);
      checkOutput("t3_domain_rst_e46", 32'(domainRst), 32'h2);
      checkOutput("t3_all_ready_e46", 32'(allReady), 32'h0);
      tick(1);
      checkOutput("t3_domain_rst_e47", 32'(domainRst), 32'h0);
      checkOutput("t3_all_ready_e47", 32'(allReady), 32'h1);

      // Test 4: ch1 loses lock for good; PRST at 50, timeouts at 74 and 98 -> FAULT
      applyStimulus(2'b01, 2'b00);
      tick(3);
      checkOutput("t4_cnt_e50", 32'(lossCnt), 32'h8);
      tick(24);
      checkOutput("t4_pll_rst_e74", 32'(pllRst), 32'h0);
      tick(1);
      checkOutput("t4_pll_rst_e75", 32'(pllRst), 32'h2);
      checkOutput("t4_fault_e75", 32'(fault), 32'h0);
      tick(23);
      checkOutput("t4_fault_e98", 32'(fault), 32'h0);
      tick(1);
      checkOutput("t4_fault_e99", 32'(fault), 32'h2);
      checkOutput("t4_pll_rst_e99", 32'(pllRst), 32'h2);
      checkOutput("t4_domain_rst_e99", 32'(domainRst), 32'h2);
      tick(11);
      checkOutput("t4_fault_e110", 32'(fault), 32'h2);
      // fault_clr on both: ch1 restarts, ch0 in RUN ignores it
      applyStimulus(2'b01, 2'b11);
      tick(1);
      applyStimulus(2'b01, 2'b00);
      checkOutput("t4_fault_e111", 32'(fault), 32'h2);
      tick(1);
      checkOutput("t4_fault_e112", 32'(fault), 32'h0);
      checkOutput("t4_pll_rst_e112", 32'(pllRst), 32'h2);
      checkOutput("t4_domain_rst_e112", 32'(domainRst), 32'h2);
      tick(3);
      checkOutput("t4_pll_rst_e115", 32'(pllRst), 32'h2);
      tick(1);
      checkOutput("t4_pll_rst_e116", 32'(pllRst), 32'h0);

      // Test 5: five lock losses on ch0; its count saturates at 3, ch1 count stays 2
      for (int i = 0; i < 5; i++) begin
         applyStimulus(2'b00, 2'b00);
         tick(3);
         checkOutput($sformatf("t5_cnt_%0d", i), 32'(lossCnt), 32'(8 + ((i + 1 > 3) ? 3 : i + 1)));
         applyStimulus(2'b01, 2'b00);
         tick(1);
         checkOutput($sformatf("t5_pll_rst0_%0d", i), 32'(pllRst[0]), 32'h1);
         checkOutput($sformatf("t5_domain_rst0_%0d", i), 32'(domainRst[0]), 32'h1);
         tick(13);
         checkOutput($sformatf("t5_release0_%0d", i), 32'(domainRst[0]), 32'h0);
      end

      // Test 6: asynchronous reset mid-cycle while ch0 is in RUN
      #3;
      rst = 1'b1;
      #1;
      checkOutput("t6_pll_rst", 32'(pllRst), 32'h3);
      checkOutput("t6_domain_rst", 32'(domainRst), 32'h3);
      checkOutput("t6_cnt", 32'(lossCnt), 32'h0);
      checkOutput("t6_fault", 32'(fault), 32'h0);
      checkOutput("t6_all_ready", 32'(allReady), 32'h0);
      tick(2);
      rst = 1'b0;
      tick(4);
      checkOutput("t6_pll_rst_e4", 32'(pllRst), 32'h3);
      tick(1);
      checkOutput("t6_pll_rst_e5", 32'(pllRst), 32'h0);
      tick(8);
      checkOutput("t6_domain_rst_e13", 32'(domainRst), 32'h3);
      tick(1);
      checkOutput("t6_domain_rst_e14", 32'(domainRst), 32'h2);
      checkOutput("t6_cnt_e14", 32'(lossCnt), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
